comb_sweep_capture: RTL and testbench

COMB_SWEEP_CAPTURE -- requirements
Module: comb_sweep_capture

---
 rtl/comb_sweep_pkg.sv | 18 +
 rtl/comb_sweep_capture_hold.sv | 34 +++
 rtl/comb_sweep_capture.sv | 115 +++++++++++
 tb/tb_comb_sweep_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comb_sweep_pkg.sv
// Shared definitions for the combinational truth-table sweeper: FSM encoding,
// vector geometry and the last-vector test.
package comb_sweep_pkg;

    localparam int VEC_W       = 4;
    localparam int NUM_VECTORS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_last_vec(input logic [VEC_W-1:0] idx);
        return (idx == VEC_W'(NUM_VECTORS - 1));
    endfunction

endpackage

// File: rtl/comb_sweep_capture_hold.sv
// Hold timer: counts cycles a DCBA vector has been applied and flags the
// sampling cycle (count = HOLD_CYCLES-1).
module sweep_hold_timer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [3:0] LAST_COUNT = 4'(HOLD_CYCLES - 1);

    logic [3:0] r_count;

    // Hold counter: wraps to zero on the sampling cycle so the next vector gets a full hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'h0;
        end else if (clear) begin
            r_count <= 4'h0;
        end else if (enable) begin
            if (tick) begin
                r_count <= 4'h0;
            end else begin
                r_count <= r_count + 4'h1;
            end
        end
    end

    assign tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/comb_sweep_capture.sv
// Sweeps DCBA through 0..15 and captures Y of a 4-input combinational function
// into a truth table. Optional ones counter enabled by COMB_SWEEP_ONES_COUNT_EN.
module comb_sweep_capture
    import comb_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        y_in,
    output logic [3:0]  dcba_out,
    output logic [15:0] truth_out,
    output logic        busy,
    output logic        done
`ifdef COMB_SWEEP_ONES_COUNT_EN
    ,
    output logic [4:0]  ones_cnt
`endif
);

    state_t             r_state;
    state_t             w_next_state;
    logic [VEC_W-1:0]   r_index;
    logic [15:0]        r_truth;
    logic               w_tick;
    logic               w_accept;
    logic               w_sample;
    logic               w_in_sweep;

    assign w_in_sweep = (r_state == SWEEP);
    assign w_accept   = (r_state == IDLE) && start;
    assign w_sample   = w_in_sweep && w_tick;

    sweep_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clear  (!w_in_sweep),
        .enable (w_in_sweep),
        .tick   (w_tick)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = SWEEP;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SWEEP: begin
                if (w_sample && is_last_vec(r_index)) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SWEEP;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Vector index and truth-table capture; index parks on 15 rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= 4'h0;
            r_truth <= 16'h0000;
        end else if (w_accept) begin
            r_index <= 4'h0;
            r_truth <= 16'h0000;
        end else if (w_sample) begin
            r_truth[r_index] <= y_in;
            if (!is_last_vec(r_index)) begin
                r_index <= r_index + 4'h1;
            end
        end
    end

`ifdef COMB_SWEEP_ONES_COUNT_EN
    logic [4:0] r_ones;

    // Count of sampled ones; final on the cycle done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= 5'd0;
        end else if (w_accept) begin
            r_ones <= 5'd0;
        end else if (w_sample && y_in) begin
            r_ones <= r_ones + 5'd1;
        end
    end

    assign ones_cnt = r_ones;
`endif

    assign dcba_out  = w_in_sweep ? r_index : 4'h0;
    assign truth_out = r_truth;
    assign busy      = w_in_sweep;
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_comb_sweep_capture.sv
// Self-checking bench for comb_sweep_capture with HOLD_CYCLES = 1 and 3 instances;
// the downstream function is modelled in the bench and results compared to its truth table.
module tb_comb_sweep_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s;
    logic        sel;
    int          mode;
    logic [15:0] tt_cur;

    logic        start1, start3, y1, y3, busy1, busy3, done1, done3;
    logic [3:0]  dcba1, dcba3;
    logic [15:0] truth1, truth3;
    logic        m_busy, m_done;
    logic [3:0]  m_dcba;
    logic [15:0] m_truth;
`ifdef COMB_SWEEP_ONES_COUNT_EN
    logic [4:0]  ones1, ones3, m_ones;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic fn(input int md, input logic [3:0] v, input logic [15:0] tt);
        case (md)
            0:       return v[0];
            1:       return &v;
            2:       return ^v;
            default: return tt[v];
        endcase
    endfunction

    assign y1     = fn(mode, dcba1, tt_cur);
    assign y3     = fn(mode, dcba3, tt_cur);
    assign start1 = start_s & ~sel;
    assign start3 = start_s & sel;
    assign m_busy  = sel ? busy3  : busy1;
    assign m_done  = sel ? done3  : done1;
    assign m_dcba  = sel ? dcba3  : dcba1;
    assign m_truth = sel ? truth3 : truth1;
`ifdef COMB_SWEEP_ONES_COUNT_EN
    assign m_ones  = sel ? ones3  : ones1;
`endif

    comb_sweep_capture #(.HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1),
        .dcba_out(dcba1), .truth_out(truth1), .busy(busy1), .done(done1)
`ifdef COMB_SWEEP_ONES_COUNT_EN
        , .ones_cnt(ones1)
`endif
    );

    comb_sweep_capture #(.HOLD_CYCLES(3)) u_h3 (
        .clk(clk), .rst(rst), .start(start3), .y_in(y3),
        .dcba_out(dcba3), .truth_out(truth3), .busy(busy3), .done(done3)
`ifdef COMB_SWEEP_ONES_COUNT_EN
        , .ones_cnt(ones3)
`endif
    );

    // Run one sweep on the selected instance and check it against the expected table.
    task automatic run_sweep(input int h, input logic [15:0] exp_tt, input bit keep_start,
                             input bit repulse);
        int c, busy_cycles, hold_errs;
        bit accepted;
        sel      = (h == 3);
        start_s  = 1'b1;
        accepted = 1'b0;
        @(posedge clk); #1;
        accepted = m_busy;
        n_tests++;
        if (accepted !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_h%0d: busy=%b required 1", h, m_busy);
            start_s = 1'b0;
            return;
        end
        if (!keep_start) start_s = 1'b0;
        n_tests++;
        if (m_truth !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear_on_start_h%0d: truth=%h required 0000", h, m_truth);
        end
        c = 0; busy_cycles = 0; hold_errs = 0;
        while (!m_done && c <= 16 * h + 4) begin
            if (m_busy) busy_cycles++;
            if (m_dcba !== 4'(c / h)) hold_errs++;
            if (repulse) start_s = ((c / h) == 5) && ((c % h) == 0);
            @(posedge clk); #1;
            c++;
        end
        if (repulse) start_s = 1'b0;
        n_tests++;
        if (m_done !== 1'b1 || c != 16 * h) begin
            n_fail++;
            $display("FAIL done_latency_h%0d: done=%b after %0d edges required 1 after %0d", h, m_done, c, 16 * h);
        end
        n_tests++;
        if (busy_cycles != 16 * h) begin
            n_fail++;
            $display("FAIL busy_cycles_h%0d: got %0d required %0d", h, busy_cycles, 16 * h);
        end
        n_tests++;
        if (hold_errs != 0) begin
            n_fail++;
            $display("FAIL dcba_hold_h%0d: %0d cycles with wrong vector required 0", h, hold_errs);
        end
        n_tests++;
        if (m_truth !== exp_tt) begin
            n_fail++;
            $display("FAIL truth_h%0d: got %h required %h", h, m_truth, exp_tt);
        end
        n_tests++;
        if (m_busy !== 1'b0 || m_dcba !== 4'h0) begin
            n_fail++;
            $display("FAIL done_state_outs_h%0d: busy=%b dcba=%h required 0 0", h, m_busy, m_dcba);
        end
`ifdef COMB_SWEEP_ONES_COUNT_EN
        n_tests++;
        if (m_ones !== 5'($countones(exp_tt))) begin
            n_fail++;
            $display("FAIL ones_cnt_h%0d: got %0d required %0d", h, m_ones, $countones(exp_tt));
        end
`endif
        @(posedge clk); #1;
        n_tests++;
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_truth !== exp_tt) begin
            n_fail++;
            $display("FAIL after_done_h%0d: done=%b busy=%b truth=%h required 0 0 %h",
                     h, m_done, m_busy, m_truth, exp_tt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_s = 1'b0; sel = 1'b0; mode = 0; tt_cur = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy1, done1, dcba1, truth1, busy3, done3, dcba3, truth3} !== 44'h0) begin
            n_fail++;
            $display("FAIL reset_state: h1 %b%b%h%h h3 %b%b%h%h required all 0",
                     busy1, done1, dcba1, truth1, busy3, done3, dcba3, truth3);
        end
        rst = 1'b0;
    endtask

    task automatic test_walk_a();
        mode = 0;
        run_sweep(1, 16'hAAAA, 1'b0, 1'b0);
    endtask

    task automatic test_and();
        mode = 1;
        run_sweep(1, 16'h8000, 1'b0, 1'b0);
    endtask

    task automatic test_xor_hold3();
        mode = 2;
        run_sweep(3, 16'h6996, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        mode = 3;
        for (int i = 0; i < 4; i++) begin
            tt_cur = 16'($urandom);
            run_sweep((i % 2 == 0) ? 1 : 3, tt_cur, 1'b0, 1'b0);
        end
    endtask

    // Asynchronous reset at vector 7, then a clean sweep.
    task automatic test_reset_mid(input int h);
        int w;
        mode = 3; tt_cur = 16'hFFFF;
        sel = (h == 3); start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        w = 0;
        while (m_dcba !== 4'h7 && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        n_tests++;
        if (m_dcba !== 4'h7 || m_truth !== 16'h007F) begin
            n_fail++;
            $display("FAIL reach_vec7_h%0d: dcba=%h truth=%h required 7 007f", h, m_dcba, m_truth);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({m_busy, m_done, m_dcba, m_truth} !== 22'h0) begin
            n_fail++;
            $display("FAIL async_reset_h%0d: busy=%b done=%b dcba=%h truth=%h required all 0",
                     h, m_busy, m_done, m_dcba, m_truth);
        end
`ifdef COMB_SWEEP_ONES_COUNT_EN
        n_tests++;
        if (m_ones !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset_ones_h%0d: got %0d required 0", h, m_ones);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (m_busy !== 1'b0 || m_truth !== 16'h0000) begin
            n_fail++;
            $display("FAIL post_reset_idle_h%0d: busy=%b truth=%h required 0 0000", h, m_busy, m_truth);
        end
        tt_cur = 16'($urandom);
        run_sweep(h, tt_cur, 1'b0, 1'b0);
    endtask

    task automatic test_restart_ignored();
        mode = 3;
        tt_cur = 16'($urandom);
        run_sweep(1, tt_cur, 1'b0, 1'b1);
        tt_cur = 16'($urandom);
        run_sweep(3, tt_cur, 1'b0, 1'b1);
    endtask

    // start held high: one IDLE cycle separates done from the next busy.
    task automatic test_back_to_back();
        mode = 3;
        tt_cur = 16'($urandom);
        run_sweep(1, tt_cur, 1'b1, 1'b0);
        tt_cur = 16'($urandom);
        run_sweep(1, tt_cur, 1'b0, 1'b0);
        tt_cur = 16'($urandom);
        run_sweep(3, tt_cur, 1'b1, 1'b0);
        tt_cur = 16'($urandom);
        run_sweep(3, tt_cur, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_walk_a();
        test_and();
        test_xor_hold3();
        test_random();
        test_reset_mid(1);
        test_reset_mid(3);
        test_restart_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
